reset_seq_ctrl: RTL and testbench
=================================

RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 3, meaning the depth of the reset and lock synchroniser chains; legal range 2..8.
REQ-002 The block SHALL have parameter NUM_OUT, default 4, meaning the number of sequenced reset outputs; legal range 1..16.
REQ-003 The block SHALL have parameter STRETCH_CYCLES, default 16, meaning the minimum reset hold after sources are clean; legal range 1..65535.
REQ-004 The block SHALL have parameter STAGE_GAP, default 8, meaning the cycles between consecutive output releases; legal range 1..65535.
REQ-005 The block SHALL have port clk, input, 1 bit, destination clock.
REQ-006 The block SHALL have port nRST, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port pll_locked, input, 1 bit, asynchronous clock-source lock indication, active high.
REQ-008 The block SHALL have port sw_rst_req, input, 1 bit, clk-synchronous level soft-reset request, active high.
REQ-009 The block SHALL have port rst_n, output, NUM_OUT bits, sequenced synchronous-release resets, active low.
REQ-010 The block SHALL have port rst_done, output, 1 bit, high when all outputs are released.
REQ-011 The block SHALL have port state, output, 2 bits, FSM state: HOLD=0, RELEASE=1, DONE=2; 3 is unused.

Function
REQ-012 The block SHALL synchronise nRST release through a SYNC_STAGES flop chain.
- Chain is async-cleared by nRST and shifts in 1.
- Output rst_sync goes high on edge SYNC_STAGES after nRST rises.
REQ-013 The block SHALL synchronise pll_locked through a SYNC_STAGES flop chain into lock_sync.
- Chain is async-cleared by nRST.
REQ-014 The block SHALL treat pll_locked low pulses shorter than one clk period as not guaranteed to be detected.
REQ-015 The block SHALL drive all outputs directly from flops; there SHALL be no combinational path from any input to any output.
REQ-016 In HOLD, the block SHALL increment the counter on each cycle where rst_sync=1, lock_sync=1 and sw_rst_req=0; otherwise the counter SHALL be cleared to 0.
REQ-017 When the counter equals STRETCH_CYCLES-1 with count conditions true, the block SHALL, on that edge:
- move to RELEASE;
- set rst_n[0]=1;
- clear the counter.
REQ-018 In RELEASE, the block SHALL set rst_n[k+1]=1 exactly STAGE_GAP edges after rst_n[k] rose, in ascending index order.
- Once released, a bit SHALL stay high until an abort.
REQ-019 On the edge that releases rst_n[NUM_OUT-1], the block SHALL:
- move to DONE;
- set rst_done=1.
- When NUM_OUT=1, this is the edge of REQ-017.
REQ-020 In RELEASE or DONE, an abort SHALL occur when lock_sync=0 or sw_rst_req=1 is sampled. On the next edge the block SHALL:
- set all rst_n=0 and rst_done=0;
- clear the counter;
- enter HOLD.
REQ-021 In HOLD, the block SHALL keep all rst_n bits at 0 while sw_rst_req=1 or lock_sync=0; counting restarts from 0 on the first cycle both are clean.
REQ-022 When an abort and a release fall on the same edge, the abort SHALL win.
REQ-023 The counter SHALL be $clog2(max(STRETCH_CYCLES,STAGE_GAP)+1) bits wide and SHALL never wrap.

Reset
REQ-024 While nRST=0, the block SHALL asynchronously hold:
- rst_n=0, rst_done=0, state=HOLD;
- counter=0 and both sync chains=0.
REQ-025 The block SHALL apply nRST assertion immediately in any state, including mid-RELEASE, independent of clk.
REQ-026 The block SHALL deassert nRST only through the REQ-012 chain, never directly to any output.

Verification
REQ-027 Defaults, pll_locked=1, nRST rises before edge 1. The bench SHALL check:
- rst_n[0] high after edge 19;
- rst_n[1] after 27, rst_n[2] after 35, rst_n[3] after 43;
- rst_done and state=2 after edge 43.
REQ-028 nRST pulsed low mid-RELEASE (after edge 30) -> rst_n=0 and rst_done=0 within the same clock period, before the next edge; the full REQ-027 timing repeats from the nRST rise.
REQ-029 pll_locked dropped for 4 cycles while in DONE -> all rst_n=0 on edge SYNC_STAGES+1 after the drop; re-release follows REQ-017/018 counted from lock_sync rising.
REQ-030 sw_rst_req held high 5 cycles while in DONE -> rst_n=0 on the next edge; rst_n[0] rises STRETCH_CYCLES edges after sw_rst_req low is first sampled.
REQ-031 NUM_OUT=1, STRETCH_CYCLES=1, SYNC_STAGES=2 -> rst_n[0], rst_done and state=2 all rise together after edge 3.
REQ-032 Abort sampled on the same edge as a scheduled rst_n[2] release -> rst_n[2] stays 0 and state=HOLD.

Source files
------------

// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: synchronises the board reset and PLL lock, stretches the
// reset once both are clean, then releases NUM_OUT active-low resets one at
// a time, STAGE_GAP cycles apart. Loss of lock or a soft-reset request
// collapses every output back to reset. All outputs are flop-driven.
module reset_seq_ctrl #(
    parameter int SYNC_STAGES    = 3,
    parameter int NUM_OUT        = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               pll_locked,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_n,
    output logic               rst_done,
    output logic [1:0]         state
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_rst_chain;
    logic [SYNC_STAGES-1:0] r_lock_chain;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_OUT-1:0]     r_rst_n;
    logic                   r_rst_done;

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [NUM_OUT-1:0]     w_rst_n_nxt;
    logic                   w_rst_done_nxt;
    logic [NUM_OUT-1:0]     w_shift;
    logic                   w_rst_sync;
    logic                   w_lock_sync;
    logic                   w_clean;
    logic                   w_abort;

    // Reset-release synchroniser: asserts asynchronously, releases after SYNC_STAGES edges.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_rst_chain <= {SYNC_STAGES{1'b0}};
        end else begin
            r_rst_chain <= {r_rst_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // PLL lock synchroniser into the clk domain.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_lock_chain <= {SYNC_STAGES{1'b0}};
        end else begin
            r_lock_chain <= {r_lock_chain[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_rst_sync  = r_rst_chain[SYNC_STAGES-1];
    assign w_lock_sync = r_lock_chain[SYNC_STAGES-1];
    assign w_clean     = w_rst_sync & w_lock_sync & ~sw_rst_req;
    assign w_abort     = ~w_clean;

    // Next release pattern: shift one more released bit in from index 0 upward.
    assign w_shift = NUM_OUT'({r_rst_n, 1'b1});

    // Sequencer next-state, counter and output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rst_n_nxt    = r_rst_n;
        w_rst_done_nxt = r_rst_done;
        case (r_state)
            ST_HOLD: begin
                w_rst_n_nxt    = {NUM_OUT{1'b0}};
                w_rst_done_nxt = 1'b0;
                if (w_clean) begin
                    if (r_cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
                        w_cnt_nxt   = {CNT_W{1'b0}};
                        w_rst_n_nxt = w_shift;
                        if (&w_shift) begin
                            w_state_nxt    = ST_DONE;
                            w_rst_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt    = ST_RELEASE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                end
            end
            ST_RELEASE: begin
                // Abort takes priority over a release due on the same edge.
                if (w_abort) begin
                    w_state_nxt    = ST_HOLD;
                    w_cnt_nxt      = {CNT_W{1'b0}};
                    w_rst_n_nxt    = {NUM_OUT{1'b0}};
                    w_rst_done_nxt = 1'b0;
                end else if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_rst_n_nxt = w_shift;
                    if (&w_shift) begin
                        w_state_nxt    = ST_DONE;
                        w_rst_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (w_abort) begin
                    w_state_nxt    = ST_HOLD;
                    w_cnt_nxt      = {CNT_W{1'b0}};
                    w_rst_n_nxt    = {NUM_OUT{1'b0}};
                    w_rst_done_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                end
            end
            default: begin
                w_state_nxt    = ST_HOLD;
                w_cnt_nxt      = {CNT_W{1'b0}};
                w_rst_n_nxt    = {NUM_OUT{1'b0}};
                w_rst_done_nxt = 1'b0;
            end
        endcase
    end

    // Sequencer state and output registers; nRST forces everything into reset at once.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state    <= ST_HOLD;
            r_cnt      <= {CNT_W{1'b0}};
            r_rst_n    <= {NUM_OUT{1'b0}};
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rst_n    <= w_rst_n_nxt;
            r_rst_done <= w_rst_done_nxt;
        end
    end

    assign rst_n    = r_rst_n;
    assign rst_done = r_rst_done;
    assign state    = r_state;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: default instance for the full sequence,
// aborts and async reset; a minimal instance for the single-output corner.
module tb_reset_seq_ctrl;

    logic       clk;
    logic       nrst_a;
    logic       pll_a;
    logic       sw_a;
    logic [3:0] rst_n_a;
    logic       done_a;
    logic [1:0] state_a;

    logic       nrst_b;
    logic       pll_b;
    logic       sw_b;
    logic [0:0] rst_n_b;
    logic       done_b;
    logic [1:0] state_b;

    int n_chk;
    int n_pass;
    int e;

    reset_seq_ctrl u_dut_a (
        .clk        (clk),
        .nRST       (nrst_a),
        .pll_locked (pll_a),
        .sw_rst_req (sw_a),
        .rst_n      (rst_n_a),
        .rst_done   (done_a),
        .state      (state_a)
    );

    reset_seq_ctrl #(
        .SYNC_STAGES    (2),
        .NUM_OUT        (1),
        .STRETCH_CYCLES (1),
        .STAGE_GAP      (8)
    ) u_dut_b (
        .clk        (clk),
        .nRST       (nrst_b),
        .pll_locked (pll_b),
        .sw_rst_req (sw_b),
        .rst_n      (rst_n_b),
        .rst_done   (done_b),
        .state      (state_b)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    // Advance to edge 'target' counted from the last nRST rise, then settle 1 ns.
    task automatic goto(input int target);
        while (e < target) begin
            @(posedge clk);
            e = e + 1;
        end
        #1;
    endtask

    // Full default release timeline from an nRST rise before edge 1.
    task automatic check_timeline(input string pfx);
        goto(18);
        chk({pfx, "_pre_rel0"}, {28'd0, rst_n_a}, 32'h0);
        goto(19);
        chk({pfx, "_rel0"}, {28'd0, rst_n_a}, 32'h1);
        chk({pfx, "_st_rel"}, {30'd0, state_a}, 32'd1);
        goto(26);
        chk({pfx, "_pre_rel1"}, {28'd0, rst_n_a}, 32'h1);
        goto(27);
        chk({pfx, "_rel1"}, {28'd0, rst_n_a}, 32'h3);
        goto(35);
        chk({pfx, "_rel2"}, {28'd0, rst_n_a}, 32'h7);
        goto(42);
        chk({pfx, "_pre_done"}, {31'd0, done_a}, 32'd0);
        goto(43);
        chk({pfx, "_rel3"}, {28'd0, rst_n_a}, 32'hF);
        chk({pfx, "_done"}, {31'd0, done_a}, 32'd1);
        chk({pfx, "_st_done"}, {30'd0, state_a}, 32'd2);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        e      = 0;
        nrst_a = 1'b0;
        pll_a  = 1'b1;
        sw_a   = 1'b0;
        nrst_b = 1'b0;
        pll_b  = 1'b1;
        sw_b   = 1'b0;

        // Reset state while nRST is low, across a couple of edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rst_n", {28'd0, rst_n_a}, 32'h0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_state", {30'd0, state_a}, 32'd0);
        chk("rst_b_rst_n", {31'd0, rst_n_b}, 32'd0);

        // Power-on sequence.
        nrst_a = 1'b1;
        e = 0;
        check_timeline("por");

        // Restart, then pulse nRST low mid-RELEASE after edge 30.
        nrst_a = 1'b0;
        #1;
        nrst_a = 1'b1;
        e = 0;
        goto(30);
        chk("mid_rel_pre", {28'd0, rst_n_a}, 32'h3);
        nrst_a = 1'b0;
        #1;
        chk("async_rst_n", {28'd0, rst_n_a}, 32'h0);
        chk("async_done", {31'd0, done_a}, 32'd0);
        chk("async_state", {30'd0, state_a}, 32'd0);
        #1;
        nrst_a = 1'b1;
        e = 0;
        check_timeline("rerun");

        // PLL lock lost for 4 cycles while DONE.
        pll_a = 1'b0;
        goto(46);
        chk("pll_pre_abort", {28'd0, rst_n_a}, 32'hF);
        goto(47);
        chk("pll_abort", {28'd0, rst_n_a}, 32'h0);
        chk("pll_abort_st", {30'd0, state_a}, 32'd0);
        chk("pll_abort_done", {31'd0, done_a}, 32'd0);
        pll_a = 1'b1;
        goto(65);
        chk("pll_pre_rel0", {28'd0, rst_n_a}, 32'h0);
        goto(66);
        chk("pll_rel0", {28'd0, rst_n_a}, 32'h1);
        goto(90);
        chk("pll_redone", {28'd0, rst_n_a}, 32'hF);
        chk("pll_redone_st", {30'd0, state_a}, 32'd2);

        // Soft reset held 5 cycles while DONE.
        sw_a = 1'b1;
        goto(91);
        chk("sw_abort", {28'd0, rst_n_a}, 32'h0);
        chk("sw_abort_st", {30'd0, state_a}, 32'd0);
        goto(95);
        sw_a = 1'b0;
        goto(110);
        chk("sw_pre_rel0", {28'd0, rst_n_a}, 32'h0);
        goto(111);
        chk("sw_rel0", {28'd0, rst_n_a}, 32'h1);

        // Abort sampled on the edge that would release rst_n[2].
        goto(126);
        chk("race_pre", {28'd0, rst_n_a}, 32'h3);
        sw_a = 1'b1;
        goto(127);
        chk("race_bit2", {31'd0, rst_n_a[2]}, 32'd0);
        chk("race_rst_n", {28'd0, rst_n_a}, 32'h0);
        chk("race_state", {30'd0, state_a}, 32'd0);
        sw_a = 1'b0;
        goto(142);
        chk("race_pre_rel0", {28'd0, rst_n_a}, 32'h0);
        goto(143);
        chk("race_rel0", {28'd0, rst_n_a}, 32'h1);

        // Single-output, 1-cycle stretch, 2-stage sync instance.
        nrst_b = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("b_edge2_rst_n", {31'd0, rst_n_b}, 32'd0);
        chk("b_edge2_state", {30'd0, state_b}, 32'd0);
        @(posedge clk);
        #1;
        chk("b_edge3_rst_n", {31'd0, rst_n_b}, 32'd1);
        chk("b_edge3_done", {31'd0, done_b}, 32'd1);
        chk("b_edge3_state", {30'd0, state_b}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
